ddr_cmd_driver: RTL and testbench

DDR_CMD_DRIVER -- requirements
Module: ddr_cmd_driver

---
 rtl/ddr_cmd_driver.sv | 196 +++++++++++++++++++
 tb/tb_ddr_cmd_driver.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_cmd_driver.sv
// DDR4 single-request command sequencer: ACT / tRCD / CAS,
// then CWL wait and an 8-bit BL8/BC4 write burst with strobes.
module ddr_cmd_driver #(
  parameter int T_RCD = 4,
  parameter int CWL   = 9
) (
  input  logic        CK_t,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic        req_no_act,
  input  logic        req_bl8,
  input  logic [1:0]  req_bg,
  input  logic [1:0]  req_ba,
  input  logic [16:0] req_row,
  input  logic [9:0]  req_col,
  input  logic [63:0] req_data,
  output logic        cs_n,
  output logic        act_n,
  output logic        RAS_n_A16,
  output logic        CAS_n_A15,
  output logic        WE_n_A14,
  output logic        A13,
  output logic        A12_BC_n,
  output logic        A11,
  output logic        A10_AP,
  output logic [1:0]  bg_addr,
  output logic [1:0]  ba_addr,
  output logic [9:0]  A9_A0,
  output logic [7:0]  dq,
  output logic        dq_oe,
  output logic        dqs_t,
  output logic        dqs_c,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE, ACT, TRCD, CAS, WLAT, BURST
  } state_t;

  localparam logic [4:0] TRCD_LOAD = 5'(T_RCD - 2);
  localparam logic [4:0] CWL_LOAD  = 5'(CWL - 2);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  beat_q, beat_d;
  logic        done_q, done_d;
  logic        wr_q, wr_d;
  logic        bl8_q, bl8_d;
  logic [1:0]  bg_q, bg_d;
  logic [1:0]  ba_q, ba_d;
  logic [16:0] row_q, row_d;
  logic [9:0]  col_q, col_d;
  logic [63:0] data_q, data_d;
  logic        last_beat;

  assign last_beat = bl8_q ? (beat_q == 3'd7)
                           : (beat_q == 3'd3);

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      done_q  <= 1'b0;
      wr_q    <= 1'b0;
      bl8_q   <= 1'b0;
      bg_q    <= '0;
      ba_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
      wr_q    <= wr_d;
      bl8_q   <= bl8_d;
      bg_q    <= bg_d;
      ba_q    <= ba_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    done_d  = 1'b0;
    wr_d    = wr_q;
    bl8_d   = bl8_q;
    bg_d    = bg_q;
    ba_d    = ba_q;
    row_d   = row_q;
    col_d   = col_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_wr;
          bl8_d   = req_bl8;
          bg_d    = req_bg;
          ba_d    = req_ba;
          row_d   = req_row;
          col_d   = req_col;
          data_d  = req_data;
          state_d = req_no_act ? CAS : ACT;
        end
      end
      ACT: begin
        cnt_d   = TRCD_LOAD;
        state_d = (T_RCD == 1) ? CAS : TRCD;
      end
      TRCD: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = CAS;
      end
      CAS: begin
        beat_d = 3'd0;
        cnt_d  = CWL_LOAD;
        if (!wr_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = (CWL == 1) ? BURST : WLAT;
        end
      end
      WLAT: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = BURST;
      end
      BURST: begin
        if (last_beat) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          beat_d = beat_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Command/data pins decode straight from registered state.
  always_comb begin
    cs_n      = 1'b1;
    act_n     = 1'b1;
    RAS_n_A16 = 1'b1;
    CAS_n_A15 = 1'b1;
    WE_n_A14  = 1'b1;
    A13       = 1'b0;
    A12_BC_n  = 1'b0;
    A11       = 1'b0;
    A10_AP    = 1'b0;
    bg_addr   = 2'd0;
    ba_addr   = 2'd0;
    A9_A0     = 10'd0;
    dq        = 8'd0;
    dq_oe     = 1'b0;
    dqs_t     = 1'b0;
    dqs_c     = 1'b1;
    if (state_q == ACT) begin
      cs_n    = 1'b0;
      act_n   = 1'b0;
      {RAS_n_A16, CAS_n_A15, WE_n_A14, A13,
       A12_BC_n, A11, A10_AP} = row_q[16:10];
      A9_A0   = row_q[9:0];
      bg_addr = bg_q;
      ba_addr = ba_q;
    end
    if (state_q == CAS) begin
      cs_n      = 1'b0;
      RAS_n_A16 = 1'b1;
      CAS_n_A15 = 1'b0;
      WE_n_A14  = ~wr_q;
      A12_BC_n  = bl8_q;
      A9_A0     = col_q;
      bg_addr   = bg_q;
      ba_addr   = ba_q;
    end
    if (state_q == BURST) begin
      dq    = data_q[{beat_q, 3'b000} +: 8];
      dq_oe = 1'b1;
      dqs_t = ~beat_q[0];
      dqs_c = beat_q[0];
    end
  end

  assign req_ready = (state_q == IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_ddr_cmd_driver.sv
// Directed bench for ddr_cmd_driver: default timing plus a
// T_RCD=1/CWL=1 instance; compares all pins every cycle.
module tb_ddr_cmd_driver;

  logic        CK_t = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic        req_no_act = 1'b0;
  logic        req_bl8 = 1'b0;
  logic [1:0]  req_bg = '0;
  logic [1:0]  req_ba = '0;
  logic [16:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic [63:0] req_data = '0;

  logic req_ready, cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
  logic A13, A12_BC_n, A11, A10_AP, dq_oe, dqs_t, dqs_c, done;
  logic [1:0] bg_addr, ba_addr;
  logic [9:0] A9_A0;
  logic [7:0] dq;

  logic req_ready_f, cs_n_f, act_n_f, RAS_f, CAS_f, WE_f;
  logic A13_f, A12_f, A11_f, A10_f, dq_oe_f, dqs_t_f, dqs_c_f;
  logic done_f;
  logic [1:0] bg_f, ba_f;
  logic [9:0] A9_f;
  logic [7:0] dq_f;

  int checks = 0;
  int failures = 0;

  localparam logic [8:0] NOP = 9'b111110000;

  logic [35:0] obs, obs_f;
  assign obs = {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14,
                A13, A12_BC_n, A11, A10_AP, bg_addr, ba_addr,
                A9_A0, dq, dq_oe, dqs_t, dqs_c, done,
                req_ready};
  assign obs_f = {cs_n_f, act_n_f, RAS_f, CAS_f, WE_f,
                  A13_f, A12_f, A11_f, A10_f, bg_f, ba_f,
                  A9_f, dq_f, dq_oe_f, dqs_t_f, dqs_c_f,
                  done_f, req_ready_f};

  always #5 CK_t = ~CK_t;

  ddr_cmd_driver dut (
    .CK_t(CK_t), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_no_act(req_no_act),
    .req_bl8(req_bl8), .req_bg(req_bg), .req_ba(req_ba),
    .req_row(req_row), .req_col(req_col),
    .req_data(req_data),
    .cs_n(cs_n), .act_n(act_n), .RAS_n_A16(RAS_n_A16),
    .CAS_n_A15(CAS_n_A15), .WE_n_A14(WE_n_A14),
    .A13(A13), .A12_BC_n(A12_BC_n), .A11(A11),
    .A10_AP(A10_AP), .bg_addr(bg_addr), .ba_addr(ba_addr),
    .A9_A0(A9_A0), .dq(dq), .dq_oe(dq_oe),
    .dqs_t(dqs_t), .dqs_c(dqs_c), .done(done)
  );

  ddr_cmd_driver #(.T_RCD(1), .CWL(1)) dut_f (
    .CK_t(CK_t), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready_f),
    .req_wr(req_wr), .req_no_act(req_no_act),
    .req_bl8(req_bl8), .req_bg(req_bg), .req_ba(req_ba),
    .req_row(req_row), .req_col(req_col),
    .req_data(req_data),
    .cs_n(cs_n_f), .act_n(act_n_f), .RAS_n_A16(RAS_f),
    .CAS_n_A15(CAS_f), .WE_n_A14(WE_f),
    .A13(A13_f), .A12_BC_n(A12_f), .A11(A11_f),
    .A10_AP(A10_f), .bg_addr(bg_f), .ba_addr(ba_f),
    .A9_A0(A9_f), .dq(dq_f), .dq_oe(dq_oe_f),
    .dqs_t(dqs_t_f), .dqs_c(dqs_c_f), .done(done_f)
  );

  function automatic logic [35:0] mk(
    input logic [8:0] cmd, input logic [13:0] addr,
    input logic [10:0] dpins, input logic dn,
    input logic rdy);
    return {cmd, addr, dpins, dn, rdy};
  endfunction

  task automatic tick();
    @(posedge CK_t);
    #1;
  endtask

  task automatic set_req(
    input logic wr, input logic no_act, input logic bl8,
    input logic [1:0] bg, input logic [1:0] ba,
    input logic [16:0] row, input logic [9:0] col,
    input logic [63:0] data);
    req_wr = wr; req_no_act = no_act; req_bl8 = bl8;
    req_bg = bg; req_ba = ba; req_row = row;
    req_col = col; req_data = data;
  endtask

  task automatic test_reset();
    logic [35:0] e;
    reset_n = 1'b0;
    #3;
    e = mk(NOP, 14'd0, 11'b001, 1'b0, 1'b1);
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL reset got=%h exp=%h", obs, e);
    end
    checks++;
    if (obs_f !== e) begin
      failures++;
      $display("FAIL reset_f got=%h exp=%h", obs_f, e);
    end
    @(negedge CK_t);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_write_bl8();
    logic [35:0] e;
    set_req(1, 0, 1, 2'd1, 2'd2, 17'h1ABCD, 10'h155,
            64'h0807060504030201);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 23; c++) begin
      e = mk(NOP, 14'd0, 11'b001, c == 22, c >= 22);
      if (c == 1)
        e = mk({2'b00, 7'b1101010}, {2'd1, 2'd2, 10'h3CD},
               11'b001, 0, 0);
      if (c == 5)
        e = mk(9'b011000100, {2'd1, 2'd2, 10'h155},
               11'b001, 0, 0);
      if (c >= 14 && c <= 21)
        e = mk(NOP, 14'd0,
               {8'(c - 13), 1'b1, c % 2 == 0, c % 2 != 0},
               0, 0);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL wr_bl8 cyc=%0d got=%h exp=%h",
                 c, obs, e);
      end
      tick();
    end
  endtask

  task automatic test_read();
    logic [35:0] e;
    set_req(0, 1, 1, 2'd2, 2'd1, 17'h0, 10'h3FF, 64'h0);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      e = mk(NOP, 14'd0, 11'b001, c == 2, c >= 2);
      if (c == 1)
        e = mk(9'b011010100, {2'd2, 2'd1, 10'h3FF},
               11'b001, 0, 0);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL read cyc=%0d got=%h exp=%h",
                 c, obs, e);
      end
      tick();
    end
  endtask

  task automatic test_bc4_busy_b2b();
    logic [35:0] e;
    set_req(1, 1, 0, 2'd0, 2'd3, 17'h0, 10'h0F0,
            64'hDEADBEEF44332211);
    req_valid = 1'b1;
    tick();
    for (int c = 1; c <= 17; c++) begin
      e = mk(NOP, 14'd0, 11'b001, 0, 0);
      if (c == 1)
        e = mk(9'b011000000, {2'd0, 2'd3, 10'h0F0},
               11'b001, 0, 0);
      if (c >= 10 && c <= 13)
        e = mk(NOP, 14'd0,
               {8'((c - 9) * 17), 1'b1, c % 2 == 0,
                c % 2 != 0}, 0, 0);
      if (c == 14 || c == 16)
        e = mk(NOP, 14'd0, 11'b001, 1, 1);
      if (c == 15)
        e = mk(9'b011010100, {2'd3, 2'd0, 10'h2AA},
               11'b001, 0, 0);
      if (c == 17)
        e = mk(NOP, 14'd0, 11'b001, 0, 1);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL bc4_b2b cyc=%0d got=%h exp=%h",
                 c, obs, e);
      end
      if (c <= 13)
        set_req($urandom, $urandom, $urandom,
                2'($urandom), 2'($urandom),
                17'($urandom), 10'($urandom),
                {$urandom, $urandom});
      if (c == 14)
        set_req(0, 1, 1, 2'd3, 2'd0, 17'h0, 10'h2AA, 64'h0);
      if (c == 15) req_valid = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [35:0] e;
    set_req(1, 1, 1, 2'd1, 2'd1, 17'h0, 10'h011,
            64'h0807060504030201);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c < 13; c++) tick();
    e = mk(NOP, 14'd0, 11'b00000100_1_0_1, 0, 0);
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL mid_beat3 got=%h exp=%h", obs, e);
    end
    #2 reset_n = 1'b0;
    #1;
    e = mk(NOP, 14'd0, 11'b001, 0, 1);
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL async_rst got=%h exp=%h", obs, e);
    end
    @(negedge CK_t);
    reset_n = 1'b1;
    tick();
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL post_rst cyc=%0d got=%h exp=%h",
                 c, obs, e);
      end
      tick();
    end
    set_req(0, 1, 0, 2'd0, 2'd0, 17'h0, 10'h001, 64'h0);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      e = mk(NOP, 14'd0, 11'b001, 1, 1);
      if (c == 1)
        e = mk(9'b011010000, {2'd0, 2'd0, 10'h001},
               11'b001, 0, 0);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL rst_resume cyc=%0d got=%h exp=%h",
                 c, obs, e);
      end
      tick();
    end
  endtask

  task automatic test_param_fast();
    logic [35:0] e;
    reset_n = 1'b0;
    @(negedge CK_t);
    reset_n = 1'b1;
    tick();
    set_req(1, 0, 1, 2'd2, 2'd3, 17'h00401, 10'h0AA,
            64'h8877665544332211);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      e = mk(NOP, 14'd0, 11'b001, c == 11, c >= 11);
      if (c == 1)
        e = mk({2'b00, 7'b0000001}, {2'd2, 2'd3, 10'h001},
               11'b001, 0, 0);
      if (c == 2)
        e = mk(9'b011000100, {2'd2, 2'd3, 10'h0AA},
               11'b001, 0, 0);
      if (c >= 3 && c <= 10)
        e = mk(NOP, 14'd0,
               {8'((c - 2) * 17), 1'b1, c % 2 != 0,
                c % 2 == 0}, 0, 0);
      checks++;
      if (obs_f !== e) begin
        failures++;
        $display("FAIL fast cyc=%0d got=%h exp=%h",
                 c, obs_f, e);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_write_bl8();
    test_read();
    test_bc4_busy_b2b();
    test_reset_mid();
    test_param_fast();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
